// File: rtl/p1_operand_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// p1_operand_sequencer
//   Serial two-beat operand loader, result capture and valid/ready output
//   wrapper for the N-bit two-operand logic unit.
//   Optional: P1_SEQ_TXN_COUNT_EN adds an 8-bit result handshake counter.
// Revision: 1.0
//------------------------------------------------------------------------------
module p1_operand_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_in_data,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic         i_flush,
  output logic [N-1:0] o_alu_in0,
  output logic [N-1:0] o_alu_in1,
  input  logic [N-1:0] i_alu_out,
  output logic [N-1:0] o_res_data,
  output logic         o_res_valid,
`ifdef P1_SEQ_TXN_COUNT_EN
  output logic [7:0]   o_txn_count,
`endif
  input  logic         i_res_ready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_B = 2'd1,
    S_EXEC   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic         w_in_ready;
  logic         w_accept;
  logic [N-1:0] r_alu_in0;
  logic [N-1:0] r_alu_in1;
  logic [N-1:0] r_res_data;
  logic         r_res_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (i_in_valid) w_next_state = S_WAIT_B;
      end
      S_WAIT_B: begin
        w_in_ready = 1'b1;
        if (i_in_valid) w_next_state = S_EXEC;
      end
      S_EXEC: begin
        w_next_state = S_HOLD;
      end
      S_HOLD: begin
        if (i_res_ready) w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    // Flush overrides every transition, including a concurrent beat.
    if (i_flush) w_next_state = S_IDLE;
  end

  assign w_accept = i_in_valid && w_in_ready && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_in0   <= '0;
      r_alu_in1   <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_accept && (r_state == S_IDLE))   r_alu_in0 <= i_in_data;
      if (w_accept && (r_state == S_WAIT_B)) r_alu_in1 <= i_in_data;
      if (i_flush) begin
        r_res_valid <= 1'b0;
      end else if (r_state == S_EXEC) begin
        r_res_data  <= i_alu_out;
        r_res_valid <= 1'b1;
      end else if ((r_state == S_HOLD) && i_res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

`ifdef P1_SEQ_TXN_COUNT_EN
  logic [7:0] r_txn_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn_count <= 8'd0;
    end else if ((r_state == S_HOLD) && i_res_ready && !i_flush) begin
      r_txn_count <= r_txn_count + 8'd1;
    end
  end

  assign o_txn_count = r_txn_count;
`endif

  assign o_in_ready  = w_in_ready;
  assign o_alu_in0   = r_alu_in0;
  assign o_alu_in1   = r_alu_in1;
  assign o_res_data  = r_res_data;
  assign o_res_valid = r_res_valid;

endmodule
`default_nettype wire
